// File: rtl/loom_axil_pkg.sv
// Shared types, register offsets and byte-strobe helper for the loom AXI-Lite register block.
package loom_axil_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlvErr = 2'b10
    } axil_resp_e;

    typedef enum logic [2:0] {
        RegId,
        RegIrqStatus,
        RegIrqEnable,
        RegIrqSet,
        RegScratch,
        RegInvalid
    } reg_kind_e;

    // idx is wide enough for the largest supported scratch bank (64 words)
    typedef struct packed {
        reg_kind_e  kind;
        logic [5:0] idx;
    } reg_sel_t;

    localparam logic [31:0] OffId          = 32'h0000_0000;
    localparam logic [31:0] OffIrqStatus   = 32'h0000_0004;
    localparam logic [31:0] OffIrqEnable   = 32'h0000_0008;
    localparam logic [31:0] OffIrqSet      = 32'h0000_000C;
    localparam logic [31:0] OffScratchBase = 32'h0000_0100;

    function automatic logic [31:0] loom_axil_strb_merge(
        input logic [31:0] old_data,
        input logic [31:0] new_data,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/loom_axil_reg_slave.sv
// AXI-Lite register responder: ID word, IRQ status/enable/set block and a bank of scratch registers.
// Write address and data are buffered in independent one-entry slots and committed together.
module loom_axil_reg_slave
    import loom_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned N_REGS     = 16,
    parameter int unsigned N_IRQ      = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4C4F_4F4D
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
    input  logic                  s_axil_awvalid_i,
    output logic                  s_axil_awready_o,
    input  logic [31:0]           s_axil_wdata_i,
    input  logic [3:0]            s_axil_wstrb_i,
    input  logic                  s_axil_wvalid_i,
    output logic                  s_axil_wready_o,
    output logic [1:0]            s_axil_bresp_o,
    output logic                  s_axil_bvalid_o,
    input  logic                  s_axil_bready_i,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
    input  logic                  s_axil_arvalid_i,
    output logic                  s_axil_arready_o,
    output logic [31:0]           s_axil_rdata_o,
    output logic [1:0]            s_axil_rresp_o,
    output logic                  s_axil_rvalid_o,
    input  logic                  s_axil_rready_i,
    input  logic [N_IRQ-1:0]      irq_event_i,
    output logic [N_IRQ-1:0]      irq_o
);

    localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    function automatic reg_sel_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] off;
        logic [31:0] rel;
        reg_sel_t    sel;
        off      = 32'(addr);
        off[1:0] = 2'b00;
        rel      = off - OffScratchBase;
        sel.kind = RegInvalid;
        sel.idx  = '0;
        if (off == OffId)             sel.kind = RegId;
        else if (off == OffIrqStatus) sel.kind = RegIrqStatus;
        else if (off == OffIrqEnable) sel.kind = RegIrqEnable;
        else if (off == OffIrqSet)    sel.kind = RegIrqSet;
        else if (off >= OffScratchBase && off < OffScratchBase + 32'(4 * N_REGS)) begin
            sel.kind = RegScratch;
            sel.idx  = rel[7:2];
        end
        return sel;
    endfunction

    logic                  aw_full_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic                  w_full_reg;
    logic [31:0]           w_data_reg;
    logic [3:0]            w_strb_reg;
    logic                  bvalid_reg;
    axil_resp_e            bresp_reg;
    logic                  rvalid_reg;
    axil_resp_e            rresp_reg;
    logic [31:0]           rdata_reg;
    logic [N_IRQ-1:0]      irq_status_reg;
    logic [N_IRQ-1:0]      irq_enable_reg;
    logic [31:0]           scratch_reg [N_REGS];

    logic             aw_accept;
    logic             w_accept;
    logic             ar_accept;
    logic             commit;
    reg_sel_t         wr_sel;
    reg_sel_t         rd_sel;
    logic [N_IRQ-1:0] w1c_mask;
    logic [N_IRQ-1:0] set_mask;
    logic [N_IRQ-1:0] irq_status_next;
    logic [31:0]      rdata_next;
    axil_resp_e       rresp_next;

    assign s_axil_awready_o = !aw_full_reg;
    assign s_axil_wready_o  = !w_full_reg;
    assign s_axil_arready_o = !rvalid_reg;
    assign s_axil_bvalid_o  = bvalid_reg;
    assign s_axil_bresp_o   = bresp_reg;
    assign s_axil_rvalid_o  = rvalid_reg;
    assign s_axil_rresp_o   = rresp_reg;
    assign s_axil_rdata_o   = rdata_reg;
    assign irq_o            = irq_status_reg & irq_enable_reg;

    assign aw_accept = s_axil_awvalid_i && !aw_full_reg;
    assign w_accept  = s_axil_wvalid_i && !w_full_reg;
    assign ar_accept = s_axil_arvalid_i && !rvalid_reg;
    // A new write is held off until the previous B response has been taken
    assign commit    = aw_full_reg && w_full_reg && !bvalid_reg;
    assign wr_sel    = decode(aw_addr_reg);
    assign rd_sel    = decode(s_axil_araddr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RespOkay;
        end else begin
            if (commit)         aw_full_reg <= 1'b0;
            else if (aw_accept) aw_full_reg <= 1'b1;
            if (aw_accept)      aw_addr_reg <= s_axil_awaddr_i;
            if (commit)         w_full_reg <= 1'b0;
            else if (w_accept)  w_full_reg <= 1'b1;
            if (w_accept) begin
                w_data_reg <= s_axil_wdata_i;
                w_strb_reg <= s_axil_wstrb_i;
            end
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= (wr_sel.kind == RegInvalid) ? RespSlvErr : RespOkay;
            end else if (s_axil_bready_i) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(N_REGS); i++) scratch_reg[i] <= '0;
        end else if (commit && wr_sel.kind == RegScratch) begin
            scratch_reg[wr_sel.idx[IDX_W-1:0]] <=
                loom_axil_strb_merge(scratch_reg[wr_sel.idx[IDX_W-1:0]], w_data_reg, w_strb_reg);
        end
    end

    // Set sources are OR'd in after the clear so a same-cycle set always wins
    always_comb begin
        w1c_mask = '0;
        set_mask = '0;
        if (commit && wr_sel.kind == RegIrqStatus) w1c_mask = w_data_reg[N_IRQ-1:0];
        if (commit && wr_sel.kind == RegIrqSet)    set_mask = w_data_reg[N_IRQ-1:0];
        irq_status_next = (irq_status_reg & ~w1c_mask) | set_mask | irq_event_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_status_reg <= '0;
            irq_enable_reg <= '0;
        end else begin
            irq_status_reg <= irq_status_next;
            if (commit && wr_sel.kind == RegIrqEnable) irq_enable_reg <= w_data_reg[N_IRQ-1:0];
        end
    end

    always_comb begin
        rdata_next = '0;
        rresp_next = RespOkay;
        case (rd_sel.kind)
            RegId:        rdata_next = ID_VALUE;
            RegIrqStatus: rdata_next = 32'(irq_status_reg);
            RegIrqEnable: rdata_next = 32'(irq_enable_reg);
            RegIrqSet:    rdata_next = '0;
            RegScratch:   rdata_next = scratch_reg[rd_sel.idx[IDX_W-1:0]];
            default:      rresp_next = RespSlvErr;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RespOkay;
            rdata_reg  <= '0;
        end else if (ar_accept) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rresp_next;
            rdata_reg  <= rdata_next;
        end else if (s_axil_rready_i) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule
